// File: rtl/fmul_hs_pkg.sv
// Purpose: shared types for stb/ack float-multiplier initiators (state encoding, default width).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fmul_hs_pkg;

  // IEEE-754 single precision operand/result width.
  localparam int FLOAT_W_DEF = 32;

  // Transaction phases of an stb/ack initiator. One transaction in flight at a time.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,  // waiting for an operand pair
    SEND    = 3'd1,  // strobing operands into the multiplier
    WAIT_Z  = 3'd2,  // waiting for the product strobe
    ACK_Z   = 3'd3,  // acknowledging the product for one cycle
    PRESENT = 3'd4   // result offered downstream
  } hs_state_t;

  // True in every phase that holds a transaction.
  function automatic logic hs_is_busy(input hs_state_t st);
    return st != IDLE;
  endfunction

endpackage

// File: rtl/fmul_hs_strobe.sv
// Purpose: one operand strobe holder: loads data, raises stb, holds both until ack, then flags done.
// Latency: stb rises the cycle after load; drops the cycle after ack is sampled with stb high.
// Backpressure: data and stb held indefinitely while ack stays low.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        start a new handover with load_dat
//   load_dat    operand to present
//   ack         acknowledge from the multiplier
//   dat, stb    operand and strobe towards the multiplier (registered)
//   fin         handover complete now or earlier (done flag or ack taken this edge)
module fmul_hs_strobe
  import fmul_hs_pkg::*;
#(
  parameter int W = FLOAT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         ack,
  output logic [W-1:0] dat,
  output logic         stb,
  output logic         fin
);

  logic done;

  always_ff @(posedge clk) begin
    if (rst) begin
      dat  <= '0;
      stb  <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      dat  <= load_dat;
      stb  <= 1'b1;
      done <= 1'b0;
    end else if (stb && ack) begin
      stb  <= 1'b0;
      done <= 1'b1;
    end
  end

  // Looking ahead at the ack lets the parent leave SEND on the same edge
  // that retires the last strobe, instead of one cycle later.
  assign fin = done | (stb & ack);

endmodule

// File: rtl/fmul_hs_driver.sv
// Purpose: initiator for the float multiplier stb/ack protocol between valid/ready streams.
// Latency: op accept -> res_valid is 3 cycles plus multiplier response time; one txn in flight.
// Backpressure: op_ready low outside IDLE; result and all state held while res_ready is low.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   op_a, op_b, op_valid, op_ready    upstream operand pair stream
//   mul_a/_stb/_ack, mul_b/_stb/_ack  operand handover to the multiplier
//   mul_z, mul_z_stb, mul_z_ack       product handover from the multiplier
//   res_a, res_b, res_z, res_valid,
//   res_ready                         downstream {a,b,z} result stream
//   txn_count                         completed transactions (wrapping)
//   busy                              any phase other than IDLE
//   timeout_err                       1-cycle pulse on watchdog abort
// Optional feature: define FMUL_DRV_TIMEOUT_EN to enable the WAIT_Z watchdog
// (TIMEOUT_CYC cycles); without it WAIT_Z waits forever and timeout_err is 0.
module fmul_hs_driver
  import fmul_hs_pkg::*;
#(
  parameter int FLOAT_W     = FLOAT_W_DEF,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOAT_W-1:0] op_a,
  input  logic [FLOAT_W-1:0] op_b,
  input  logic               op_valid,
  output logic               op_ready,
  output logic [FLOAT_W-1:0] mul_a,
  output logic               mul_a_stb,
  input  logic               mul_a_ack,
  output logic [FLOAT_W-1:0] mul_b,
  output logic               mul_b_stb,
  input  logic               mul_b_ack,
  input  logic [FLOAT_W-1:0] mul_z,
  input  logic               mul_z_stb,
  output logic               mul_z_ack,
  output logic [FLOAT_W-1:0] res_a,
  output logic [FLOAT_W-1:0] res_b,
  output logic [FLOAT_W-1:0] res_z,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   txn_count,
  output logic               busy,
  output logic               timeout_err
);

  hs_state_t state, state_nxt;

  logic accept;    // operand pair taken this edge
  logic a_fin;
  logic b_fin;
  logic z_take;    // product captured this edge
  logic res_take;  // result handed downstream this edge
  logic tmo_fire;  // watchdog limit reached this cycle
  logic tmo_take;  // abort WAIT_Z this edge

  // Decoded from the state register; forced low while reset is asserted so
  // nothing is accepted on the reset edge.
  assign op_ready = (state == IDLE) & ~rst;
  assign accept   = op_valid & op_ready;

  fmul_hs_strobe #(.W(FLOAT_W)) u_stb_a (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_dat (op_a),
    .ack      (mul_a_ack),
    .dat      (mul_a),
    .stb      (mul_a_stb),
    .fin      (a_fin)
  );

  fmul_hs_strobe #(.W(FLOAT_W)) u_stb_b (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_dat (op_b),
    .ack      (mul_b_ack),
    .dat      (mul_b),
    .stb      (mul_b_stb),
    .fin      (b_fin)
  );

`ifdef FMUL_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;

  // Held at zero outside WAIT_Z, so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || (state != WAIT_Z)) begin
      wait_cnt <= '0;
    end else if (!mul_z_stb) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The count reads k-1 on the k-th edge spent in WAIT_Z, so this fires on
  // the TIMEOUT_CYC-th edge after entry.
  assign tmo_fire = (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out: never fires, whatever TIMEOUT_CYC is set to.
  assign tmo_fire = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    z_take    = 1'b0;
    res_take  = 1'b0;
    tmo_take  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        // Acks may come in either order; leave once both are in.
        if (a_fin && b_fin) begin
          state_nxt = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (mul_z_stb) begin
          z_take    = 1'b1;
          state_nxt = ACK_Z;
        end else if (tmo_fire) begin
          tmo_take  = 1'b1;
          state_nxt = IDLE;
        end
      end
      ACK_Z: begin
        state_nxt = PRESENT;
      end
      PRESENT: begin
        if (res_ready) begin
          res_take  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_z_ack   <= 1'b0;
      res_a       <= '0;
      res_b       <= '0;
      res_z       <= '0;
      res_valid   <= 1'b0;
      txn_count   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // The ack is high only during ACK_Z, which always lasts one cycle.
      mul_z_ack   <= z_take;
      timeout_err <= tmo_take;
      busy        <= hs_is_busy(state_nxt);
      if (z_take) begin
        res_a <= mul_a;
        res_b <= mul_b;
        res_z <= mul_z;
      end
      if (state == ACK_Z) begin
        res_valid <= 1'b1;
      end else if (res_take) begin
        res_valid <= 1'b0;
      end
      if (res_take) begin
        txn_count <= txn_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fmul_hs_driver.sv
// Purpose: self-checking bench for fmul_hs_driver with a cycle-level multiplier model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fmul_hs_driver;

  localparam int FW  = 32;
  localparam int CW  = 4;   // narrow counter so wrap-around is reached
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] op_a, op_b;
  logic          op_valid, op_ready;
  logic [FW-1:0] mul_a, mul_b, mul_z;
  logic          mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack;
  logic          mul_z_stb, mul_z_ack;
  logic [FW-1:0] res_a, res_b, res_z;
  logic          res_valid, res_ready;
  logic [CW-1:0] txn_count;
  logic          busy, timeout_err;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  // Observations recorded by run_txn for the calling test to judge.
  int            obs_a_stb, obs_b_stb, obs_zack, obs_lat, obs_dat_bad, obs_unstable;
  bit            obs_to;
  logic [FW-1:0] obs_ra, obs_rb, obs_rz;
  logic          obs_valid_after, obs_busy_after, obs_ready_after;
  logic [CW-1:0] obs_cnt_after;

  fmul_hs_driver #(.FLOAT_W(FW), .CNT_W(CW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .res_a(res_a), .res_b(res_b), .res_z(res_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .txn_count(txn_count), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Operands are handed over once both acks are in (edge max(da,db)+1); the
  // product is taken on the first later edge that sees z_stb, acked for one
  // cycle, and res_valid follows one cycle after that.
  function automatic int exp_latency(input int da, input int db, input int dz);
    int w;
    w = ((da > db) ? da : db) + 1;
    return ((dz > w) ? dz : w) + 2;
  endfunction

  // One full transaction. Delays count samples after the accept edge:
  // ack A pulsed at sample da, ack B at db, z_stb raised from dz until acked.
  task automatic run_txn(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic [FW-1:0] z,
                         input int da, input int db, input int dz, input int hold);
    int k;
    bit zdone;
    logic [FW-1:0] sa, sb, sz;
    obs_a_stb = 0; obs_b_stb = 0; obs_zack = 0; obs_lat = -1;
    obs_dat_bad = 0; obs_unstable = 0; obs_to = 0;
    op_a = a; op_b = b; op_valid = 1'b1; res_ready = 1'b0;
    k = 0;
    while (op_ready !== 1'b1 && k < 20) begin cyc(); k++; end
    if (op_ready !== 1'b1) begin obs_to = 1; op_valid = 1'b0; return; end
    cyc();
    op_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    k = 0; zdone = 0;
    while (obs_lat < 0 && k < 300) begin
      if (mul_a_stb === 1'b1) begin obs_a_stb++; if (mul_a !== a) obs_dat_bad++; end
      if (mul_b_stb === 1'b1) begin obs_b_stb++; if (mul_b !== b) obs_dat_bad++; end
      if (mul_z_ack === 1'b1) obs_zack++;
      if (res_valid === 1'b1) begin
        obs_lat = k;
      end else begin
        mul_a_ack = (k == da);
        mul_b_ack = (k == db);
        mul_z_stb = (k >= dz) && !zdone;
        mul_z     = z;
        if (mul_z_ack === 1'b1) zdone = 1;
        cyc();
        k++;
      end
    end
    mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0;
    if (obs_lat < 0) begin obs_to = 1; return; end
    sa = res_a; sb = res_b; sz = res_z;
    for (int i = 0; i < hold; i++) begin
      cyc();
      if (res_valid !== 1'b1 || res_a !== sa || res_b !== sb || res_z !== sz ||
          op_ready !== 1'b0 || mul_a_stb !== 1'b0 || mul_b_stb !== 1'b0 || mul_z_ack !== 1'b0)
        obs_unstable++;
    end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    obs_ra = sa; obs_rb = sb; obs_rz = sz;
    obs_valid_after = res_valid; obs_busy_after = busy;
    obs_ready_after = op_ready; obs_cnt_after = txn_count;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b1; op_a = 32'h1234_5678; op_b = 32'h9abc_def0;
    mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b1; mul_z = 32'hdead_beef; res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if ({mul_a_stb, mul_b_stb, mul_z_ack, res_valid, op_ready, timeout_err} !== 6'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got stb/ack/vld/rdy/tmo=%b want 000000", i,
                 {mul_a_stb, mul_b_stb, mul_z_ack, res_valid, op_ready, timeout_err});
      end
    end
    op_valid = 1'b0; mul_z_stb = 1'b0;
    rst = 1'b0;
    cyc();
    total++;
    if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", op_ready); end
    total++;
    if (txn_count !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_cnt_busy: got cnt=%0d busy=%b want 0 0", txn_count, busy);
    end
    total++;
    if ({mul_a, mul_b, res_a, res_b, res_z} !== '0) begin
      bad++; $display("FAIL reset_data: got a=%h z=%h want all zero", mul_a, res_z);
    end
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    run_txn(32'h3F99999A, 32'h40866666, 32'h40A147AE, 2, 3, 20, 0);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    total++;
    if (obs_to) begin bad++; $display("FAIL basic_bound: got timeout want completion"); end
    total++;
    if ({obs_ra, obs_rb, obs_rz} !== {32'h3F99999A, 32'h40866666, 32'h40A147AE}) begin
      bad++; $display("FAIL basic_result: got %h %h %h want 3f99999a 40866666 40a147ae",
                      obs_ra, obs_rb, obs_rz);
    end
    total++;
    if (obs_zack !== 1) begin bad++; $display("FAIL basic_zack: got %0d cycles want 1", obs_zack); end
    total++;
    if (obs_lat !== exp_latency(2, 3, 20)) begin
      bad++; $display("FAIL basic_latency: got %0d want %0d", obs_lat, exp_latency(2, 3, 20));
    end
    total++;
    if (obs_a_stb !== 3 || obs_b_stb !== 4 || obs_dat_bad !== 0) begin
      bad++; $display("FAIL basic_stb: got a=%0d b=%0d datbad=%0d want 3 4 0",
                      obs_a_stb, obs_b_stb, obs_dat_bad);
    end
    total++;
    if (obs_cnt_after !== CW'(exp_cnt) || obs_valid_after !== 1'b0 ||
        obs_busy_after !== 1'b0 || obs_ready_after !== 1'b1) begin
      bad++; $display("FAIL basic_done: got cnt=%0d vld=%b busy=%b rdy=%b want %0d 0 0 1",
                      obs_cnt_after, obs_valid_after, obs_busy_after, obs_ready_after, exp_cnt);
    end
  endtask

  task automatic test_ack_order();
    run_txn(32'h40400000, 32'hC0000000, 32'hC0C00000, 6, 2, 12, 0);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    total++;
    if (obs_to || obs_a_stb !== 7 || obs_b_stb !== 3) begin
      bad++; $display("FAIL order_stb: got to=%0d a=%0d b=%0d want 0 7 3", obs_to, obs_a_stb, obs_b_stb);
    end
    total++;
    if (obs_rz !== 32'hC0C00000 || obs_cnt_after !== CW'(exp_cnt) || obs_zack !== 1) begin
      bad++; $display("FAIL order_result: got z=%h cnt=%0d zack=%0d want c0c00000 %0d 1",
                      obs_rz, obs_cnt_after, obs_zack, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    run_txn(32'h3F800000, 32'h3F000000, 32'h3F000000, 1, 1, 4, 10);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    total++;
    if (obs_to || obs_unstable !== 0) begin
      bad++; $display("FAIL bp_hold: got to=%0d unstable=%0d want 0 0", obs_to, obs_unstable);
    end
    total++;
    if (obs_rz !== 32'h3F000000 || obs_cnt_after !== CW'(exp_cnt) || obs_valid_after !== 1'b0 ||
        obs_ready_after !== 1'b1) begin
      bad++; $display("FAIL bp_release: got z=%h cnt=%0d vld=%b rdy=%b want 3f000000 %0d 0 1",
                      obs_rz, obs_cnt_after, obs_valid_after, obs_ready_after, exp_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    int ack_seen;
    op_a = 32'h11111111; op_b = 32'h22222222; op_valid = 1'b1;
    cyc();  // op_ready is high in IDLE, so this edge accepts
    op_valid = 1'b0; mul_a_ack = 1'b1; mul_b_ack = 1'b1;
    cyc();
    mul_a_ack = 1'b0; mul_b_ack = 1'b0;
    cyc(); cyc();
    total++;
    if (busy !== 1'b1 || mul_a_stb !== 1'b0) begin
      bad++; $display("FAIL mid_waitz: got busy=%b stb=%b want 1 0", busy, mul_a_stb);
    end
    mul_z_stb = 1'b1; mul_z = 32'h33333333; rst = 1'b1;
    cyc();
    total++;
    if ({mul_a_stb, mul_b_stb, mul_z_ack, res_valid, op_ready, busy, timeout_err} !== 7'b0 ||
        txn_count !== '0 || mul_a !== '0 || res_z !== '0) begin
      bad++; $display("FAIL mid_reset: got flags=%b cnt=%0d a=%h z=%h want zeros",
                      {mul_a_stb, mul_b_stb, mul_z_ack, res_valid, op_ready, busy, timeout_err},
                      txn_count, mul_a, res_z);
    end
    exp_cnt = 0;
    rst = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (mul_z_ack !== 1'b0 || res_valid !== 1'b0) ack_seen++;
    end
    mul_z_stb = 1'b0;
    total++;
    if (ack_seen !== 0) begin bad++; $display("FAIL mid_stale_z: got %0d acked cycles want 0", ack_seen); end
    run_txn(32'h40000000, 32'h40000000, 32'h40800000, 0, 0, 3, 1);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    total++;
    if (obs_to || obs_rz !== 32'h40800000 || obs_cnt_after !== CW'(exp_cnt) ||
        obs_lat !== exp_latency(0, 0, 3)) begin
      bad++; $display("FAIL mid_next: got to=%0d z=%h cnt=%0d lat=%0d want 0 40800000 %0d %0d",
                      obs_to, obs_rz, obs_cnt_after, obs_lat, exp_cnt, exp_latency(0, 0, 3));
    end
  endtask

  task automatic test_random();
    logic [FW-1:0] a, b, z;
    int da, db, dz, h;
    for (int n = 0; n < 20; n++) begin
      a = $urandom; b = $urandom; z = $urandom;
      da = $urandom_range(0, 4); db = $urandom_range(0, 4);
      dz = $urandom_range(0, 8); h = $urandom_range(0, 3);
      run_txn(a, b, z, da, db, dz, h);
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      total++;
      if (obs_to || {obs_ra, obs_rb, obs_rz} !== {a, b, z}) begin
        bad++; $display("FAIL rnd_result[%0d]: got to=%0d %h %h %h want %h %h %h",
                        n, obs_to, obs_ra, obs_rb, obs_rz, a, b, z);
      end
      total++;
      if (obs_lat !== exp_latency(da, db, dz)) begin
        bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, obs_lat, exp_latency(da, db, dz));
      end
      total++;
      if (obs_a_stb !== da + 1 || obs_b_stb !== db + 1 || obs_zack !== 1) begin
        bad++; $display("FAIL rnd_hs[%0d]: got a=%0d b=%0d zack=%0d want %0d %0d 1",
                        n, obs_a_stb, obs_b_stb, obs_zack, da + 1, db + 1);
      end
      total++;
      if (obs_cnt_after !== CW'(exp_cnt) || obs_unstable !== 0 || obs_dat_bad !== 0 ||
          obs_valid_after !== 1'b0) begin
        bad++; $display("FAIL rnd_state[%0d]: got cnt=%0d unst=%0d datbad=%0d vld=%b want %0d 0 0 0",
                        n, obs_cnt_after, obs_unstable, obs_dat_bad, obs_valid_after, exp_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    int pulses, pulse_k, busy_low, vld_seen;
    logic busy_at_pulse;
    op_a = 32'h3F800000; op_b = 32'h40000000; op_valid = 1'b1;
    cyc();  // accept edge
    op_valid = 1'b0;
    pulses = 0; pulse_k = -1; busy_low = 0; vld_seen = 0; busy_at_pulse = 1'b1;
    mul_a_ack = 1'b1; mul_b_ack = 1'b1;  // both acks at sample 0
    for (int k = 1; k <= 40; k++) begin
      cyc();
      mul_a_ack = 1'b0; mul_b_ack = 1'b0;
      if (timeout_err === 1'b1) begin pulses++; pulse_k = k; busy_at_pulse = busy; end
      if (busy !== 1'b1) busy_low++;
      if (res_valid !== 1'b0) vld_seen++;
    end
`ifdef FMUL_DRV_TIMEOUT_EN
    // WAIT_Z is entered on edge 1; the abort lands TMO edges later.
    total++;
    if (pulses !== 1 || pulse_k !== 1 + TMO) begin
      bad++; $display("FAIL tmo_pulse: got n=%0d at=%0d want 1 at %0d", pulses, pulse_k, 1 + TMO);
    end
    total++;
    if (busy_at_pulse !== 1'b0 || vld_seen !== 0 || txn_count !== CW'(exp_cnt)) begin
      bad++; $display("FAIL tmo_state: got busy=%b vld=%0d cnt=%0d want 0 0 %0d",
                      busy_at_pulse, vld_seen, txn_count, exp_cnt);
    end
`else
    total++;
    if (pulses !== 0 || busy_low !== 0 || vld_seen !== 0) begin
      bad++; $display("FAIL tmo_off: got pulses=%0d busy_low=%0d vld=%0d want 0 0 0",
                      pulses, busy_low, vld_seen);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_cnt = 0;
    cyc();
    total++;
    if (busy !== 1'b0 || op_ready !== 1'b1) begin
      bad++; $display("FAIL tmo_recover: got busy=%b rdy=%b want 0 1", busy, op_ready);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_order();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
